// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register between CPU stages: valid/ready on both sides,
// synchronous flush, and an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_buf #(
  parameter int unsigned         DATA_W     = 64,
  parameter bit                  SKID_EN    = 1'b1,
  parameter logic [DATA_W-1:0]   FLUSH_DATA = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  // Handshake: a payload moves on a rising edge when valid & ready are both high
  // on that side; valid never depends on ready, and flush overrides both fires.
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = FLUSH_DATA;
      skid_valid_d = 1'b0;
      skid_data_d  = FLUSH_DATA;
    end else if (SKID_EN) begin
      if (skid_valid_q) begin
        // Full: upstream is already stalled, only the drain can happen.
        if (out_fire) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end
      end else if (main_valid_q) begin
        case ({in_fire, out_fire})
          2'b11: main_data_d = in_data;
          2'b10: begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end
          2'b01: main_valid_d = 1'b0;
          default: ;
        endcase
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else begin
      if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end
    end
  end

  // Registered copy of !skid_valid so in_ready never sees out_ready combinationally.
  assign in_ready_d = ~skid_valid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= FLUSH_DATA;
      skid_valid_q <= 1'b0;
      skid_data_q  <= FLUSH_DATA;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = SKID_EN ? in_ready_q : (out_ready | ~main_valid_q);
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid and pass-through variants at 64 bits plus 32/96-bit
// width variants, directed scenarios and a queue-model random run.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, flush;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0] a_count;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0] b_count;
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0] c_count;
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [95:0] d_in_data, d_out_data;
  logic [1:0] d_count;

  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];

  pipe_stage_buf #(.DATA_W(64), .SKID_EN(1'b1), .FLUSH_DATA(64'h0)) u_a (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count));

  pipe_stage_buf #(.DATA_W(64), .SKID_EN(1'b0), .FLUSH_DATA(64'h0)) u_b (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count));

  pipe_stage_buf #(.DATA_W(32), .SKID_EN(1'b1), .FLUSH_DATA(32'h13)) u_c (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count));

  pipe_stage_buf #(.DATA_W(96), .SKID_EN(1'b1), .FLUSH_DATA(96'h13)) u_d (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .count(d_count));

  task automatic idle_all;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    flush = 1'b0;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready); else n_pass++;
    n_checks++; if (a_count !== 2'd0) $display("FAIL reset_count: got %0d want 0", a_count); else n_pass++;
    n_checks++; if (c_out_data !== 32'h13) $display("FAIL reset_flushdata32: got %h want 13", c_out_data); else n_pass++;
    n_checks++; if (d_out_data !== 96'h13) $display("FAIL reset_flushdata96: got %h want 13", d_out_data); else n_pass++;
    // Fill the skid variant to two entries, then reset mid-cycle.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'hAAAA;
    @(negedge clk);
    a_in_data = 64'hBBBB;
    @(negedge clk);
    #1;
    n_checks++; if (a_count !== 2'd2) $display("FAIL prereset_count: got %0d want 2", a_count); else n_pass++;
    a_in_data = 64'hCCCC;
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_count !== 2'd0) $display("FAIL async_reset_count: got %0d want 0", a_count); else n_pass++;
    n_checks++; if (a_out_data !== 64'h0) $display("FAIL async_reset_data: got %h want 0", a_out_data); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (a_count !== 2'd0) $display("FAIL held_reset_count: got %0d want 0", a_count); else n_pass++;
    reset_n = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", a_in_ready); else n_pass++;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    n_checks++; if (a_count !== 2'd1) $display("FAIL release_capture_count: got %0d want 1", a_count); else n_pass++;
    n_checks++; if (a_out_data !== 64'hCCCC) $display("FAIL release_capture_data: got %h want cccc", a_out_data); else n_pass++;
    a_out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (a_count !== 2'd0) $display("FAIL release_drain_count: got %0d want 0", a_count); else n_pass++;
  endtask

  task automatic test_stream;
    a_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data = 64'(i);
      @(negedge clk);
      #1;
      n_checks++; if (a_out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, a_out_valid); else n_pass++;
      n_checks++; if (a_out_data !== 64'(i)) $display("FAIL stream_data[%0d]: got %h want %h", i, a_out_data, 64'(i)); else n_pass++;
      n_checks++; if (a_count !== 2'd1) $display("FAIL stream_count[%0d]: got %0d want 1", i, a_count); else n_pass++;
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL stream_end_valid: got %b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_data !== 64'h3) $display("FAIL stream_hold_data: got %h want 3", a_out_data); else n_pass++;
  endtask

  task automatic test_backpressure;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'h1111;
    @(negedge clk);
    a_in_data = 64'h2222;
    @(negedge clk);
    #1;
    n_checks++; if (a_count !== 2'd2) $display("FAIL bp_full_count: got %0d want 2", a_count); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", a_in_ready); else n_pass++;
    n_checks++; if (a_out_data !== 64'h1111) $display("FAIL bp_full_data: got %h want 1111", a_out_data); else n_pass++;
    a_in_data = 64'h3333;
    @(negedge clk);
    #1;
    n_checks++; if (a_count !== 2'd2) $display("FAIL bp_reject_count: got %0d want 2", a_count); else n_pass++;
    n_checks++; if (a_out_data !== 64'h1111) $display("FAIL bp_reject_data: got %h want 1111", a_out_data); else n_pass++;
    a_out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (a_out_data !== 64'h2222) $display("FAIL bp_drain_b: got %h want 2222", a_out_data); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", a_in_ready); else n_pass++;
    n_checks++; if (a_count !== 2'd1) $display("FAIL bp_drain_count: got %0d want 1", a_count); else n_pass++;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    n_checks++; if (a_out_data !== 64'h3333) $display("FAIL bp_drain_c: got %h want 3333", a_out_data); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b1) $display("FAIL bp_drain_c_valid: got %b want 1", a_out_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (a_count !== 2'd0) $display("FAIL bp_empty_count: got %0d want 0", a_count); else n_pass++;
  endtask

  task automatic test_flush_collision;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'h4444;
    @(negedge clk);
    a_in_data = 64'h5555;
    @(negedge clk);
    a_in_data = 64'h9999;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    a_in_valid = 1'b0;
    #1;
    n_checks++; if (a_count !== 2'd0) $display("FAIL flush_count: got %0d want 0", a_count); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_data !== 64'h0) $display("FAIL flush_data: got %h want 0", a_out_data); else n_pass++;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_checks++; if (a_out_valid !== 1'b0) $display("FAIL flush_no_ghost[%0d]: got %b want 0", i, a_out_valid); else n_pass++;
    end
  endtask

  task automatic test_passthrough;
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 64'hA1;
    #1;
    n_checks++; if (b_in_ready !== 1'b1) $display("FAIL pt_empty_ready: got %b want 1", b_in_ready); else n_pass++;
    @(negedge clk);
    b_in_data = 64'hA2;
    #1;
    n_checks++; if (b_in_ready !== 1'b0) $display("FAIL pt_stall_ready: got %b want 0", b_in_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (b_out_data !== 64'hA1) $display("FAIL pt_hold_data: got %h want a1", b_out_data); else n_pass++;
    n_checks++; if (b_count !== 2'd1) $display("FAIL pt_hold_count: got %0d want 1", b_count); else n_pass++;
    b_out_ready = 1'b1;
    #1;
    n_checks++; if (b_in_ready !== 1'b1) $display("FAIL pt_comb_ready: got %b want 1", b_in_ready); else n_pass++;
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    n_checks++; if (b_out_data !== 64'hA2) $display("FAIL pt_replace_data: got %h want a2", b_out_data); else n_pass++;
    n_checks++; if (b_count !== 2'd1) $display("FAIL pt_replace_count: got %0d want 1", b_count); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (b_count !== 2'd0) $display("FAIL pt_drain_count: got %0d want 0", b_count); else n_pass++;
  endtask

  task automatic test_width;
    logic [31:0] c_exp;
    logic [95:0] d_exp;
    c_out_ready = 1'b1;
    d_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_exp = {1'b1, 31'($urandom())};
      d_exp = {1'b1, 31'($urandom()), 32'($urandom()), 32'($urandom())};
      c_in_valid = 1'b1; c_in_data = c_exp;
      d_in_valid = 1'b1; d_in_data = d_exp;
      @(negedge clk);
      #1;
      n_checks++; if (c_out_data !== c_exp) $display("FAIL w32_data[%0d]: got %h want %h", i, c_out_data, c_exp); else n_pass++;
      n_checks++; if (d_out_data !== d_exp) $display("FAIL w96_data[%0d]: got %h want %h", i, d_out_data, d_exp); else n_pass++;
      n_checks++; if (d_count !== 2'd1) $display("FAIL w96_count[%0d]: got %0d want 1", i, d_count); else n_pass++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    c_in_valid = 1'b0;
    d_in_valid = 1'b0;
    #1;
    n_checks++; if (c_out_data !== 32'h13) $display("FAIL w32_flush_data: got %h want 13", c_out_data); else n_pass++;
    n_checks++; if (d_out_data !== 96'h13) $display("FAIL w96_flush_data: got %h want 13", d_out_data); else n_pass++;
    n_checks++; if (d_out_valid !== 1'b0) $display("FAIL w96_flush_valid: got %b want 0", d_out_valid); else n_pass++;
  endtask

  // Reference: a FIFO of capacity 2 (skid) or 1 (pass-through); out_data shows
  // the head, or the last value to leave (FLUSH_DATA after a flush) when empty.
  task automatic test_random(input int sel, input int cycles);
    logic [63:0] last;
    logic [63:0] dat, got_data;
    logic iv, ordy, fl, got_ready, got_valid, exp_ready, exp_valid;
    logic [1:0] got_count;
    int cap;
    cap = (sel == 0) ? 2 : 1;
    exp_q.delete();
    last = 64'h0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 31) == 0);
      dat = {32'($urandom()), 32'($urandom())};
      flush = fl;
      if (sel == 0) begin
        a_in_valid = iv; a_in_data = dat; a_out_ready = ordy;
      end else begin
        b_in_valid = iv; b_in_data = dat; b_out_ready = ordy;
      end
      #1;
      got_ready = (sel == 0) ? a_in_ready : b_in_ready;
      got_valid = (sel == 0) ? a_out_valid : b_out_valid;
      got_data = (sel == 0) ? a_out_data : b_out_data;
      got_count = (sel == 0) ? a_count : b_count;
      exp_ready = (cap == 2) ? (exp_q.size() < 2) : (ordy || exp_q.size() == 0);
      exp_valid = (exp_q.size() > 0);
      n_checks++; if (got_ready !== exp_ready) $display("FAIL rnd%0d_ready@%0d: got %b want %b", sel, cyc, got_ready, exp_ready); else n_pass++;
      n_checks++; if (got_valid !== exp_valid) $display("FAIL rnd%0d_valid@%0d: got %b want %b", sel, cyc, got_valid, exp_valid); else n_pass++;
      n_checks++; if (got_count !== 2'(exp_q.size())) $display("FAIL rnd%0d_count@%0d: got %0d want %0d", sel, cyc, got_count, exp_q.size()); else n_pass++;
      n_checks++;
      if (got_data !== (exp_valid ? exp_q[0] : last))
        $display("FAIL rnd%0d_data@%0d: got %h want %h", sel, cyc, got_data, exp_valid ? exp_q[0] : last);
      else n_pass++;
      @(negedge clk);
      if (fl) begin
        exp_q.delete();
        last = 64'h0;
      end else begin
        if (exp_valid && ordy) last = exp_q.pop_front();
        if (iv && exp_ready) exp_q.push_back(dat);
      end
    end
    flush = 1'b0;
    idle_all();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_collision();
    test_passthrough();
    test_width();
    test_random(0, 400);
    test_random(1, 400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
